// File: rtl/gates_area_pkg.sv
// Shared definitions for the gates_area block and its built-in self-test controller.
package gates_area_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;

    // Expected out_or per vector {in1,in2,in3}: only vector 000 yields 0.
    localparam logic [NUM_VEC-1:0] GATES_AREA_EXP = 8'hFE;

endpackage

// File: rtl/gates_area_bist.sv
// Self-test controller for gates_area: walks all eight input vectors, samples out_or
// after a settle time and reports mismatch count, first failing vector and pass/fail.
//
// state  | meaning
// IDLE   | waiting for start_i after reset, vector outputs 0
// DRIVE  | current vector held on in*_o for SETTLE cycles
// SAMPLE | one cycle; dut_out_i compared against EXP_TABLE at the closing edge
// DONE   | results held, done_o=1, start_i launches a fresh run
module gates_area_bist
    import gates_area_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXP_TABLE = GATES_AREA_EXP,
    parameter int                 SETTLE    = 1,
    parameter int                 ERR_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             dut_out_i,
    output logic             in1_o,
    output logic             in2_o,
    output logic             in3_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [VEC_W-1:0] first_fail_o,
    output logic             first_fail_vld_o
);

    localparam int               CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(NUM_VEC - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VEC_W-1:0]   ff_q, ff_d;
    logic               ff_vld_q, ff_vld_d;
    logic               fail_seen_q, fail_seen_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               miss;

    assign miss = (dut_out_i != EXP_TABLE[idx_q]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        ff_d        = ff_q;
        ff_vld_d    = ff_vld_q;
        fail_seen_d = fail_seen_q;
        done_d      = done_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = DRIVE;
                    idx_d       = '0;
                    cnt_d       = CNT_LOAD;
                    err_d       = '0;
                    ff_d        = '0;
                    ff_vld_d    = 1'b0;
                    fail_seen_d = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (miss) begin
                    fail_seen_d = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ff_vld_q) begin
                        ff_d     = idx_q;
                        ff_vld_d = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    // Index returns to 0 so the vector outputs idle low in DONE.
                    state_d = DONE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    pass_d  = !(fail_seen_q || miss);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + VEC_W'(1);
                    cnt_d   = CNT_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            ff_q        <= '0;
            ff_vld_q    <= 1'b0;
            fail_seen_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ff_q        <= ff_d;
            ff_vld_q    <= ff_vld_d;
            fail_seen_q <= fail_seen_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign in1_o            = idx_q[2];
    assign in2_o            = idx_q[1];
    assign in3_o            = idx_q[0];
    assign busy_o           = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_q;
    assign first_fail_o     = ff_q;
    assign first_fail_vld_o = ff_vld_q;

endmodule

// File: tb/tb_gates_area_bist.sv
// Directed bench for gates_area_bist: OR model, stuck-at faults, saturation, start
// handling and mid-run reset, with hand-computed expected results.
module tb_gates_area_bist;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [1:0] mode;      // 0: correct OR, 1: stuck-at-0, 2: stuck-at-1

    logic       in1, in2, in3, busy, done, pass, ffv;
    logic [3:0] err;
    logic [2:0] ff;
    logic       dut_out;

    logic       s_in1, s_in2, s_in3, s_busy, s_done, s_pass, s_ffv;
    logic [1:0] s_err;
    logic [2:0] s_ff;

    int n_chk  = 0;
    int n_fail = 0;

    always_comb begin
        case (mode)
            2'd1:    dut_out = 1'b0;
            2'd2:    dut_out = 1'b1;
            default: dut_out = in1 | in2 | in3;
        endcase
    end

    gates_area_bist u_dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .dut_out_i        (dut_out),
        .in1_o            (in1),
        .in2_o            (in2),
        .in3_o            (in3),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_cnt_o        (err),
        .first_fail_o     (ff),
        .first_fail_vld_o (ffv)
    );

    // Narrow counter instance, always fed a stuck-at-0 output.
    gates_area_bist #(.ERR_W(2)) u_dut_sat (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .dut_out_i        (1'b0),
        .in1_o            (s_in1),
        .in2_o            (s_in2),
        .in3_o            (s_in3),
        .busy_o           (s_busy),
        .done_o           (s_done),
        .pass_o           (s_pass),
        .err_cnt_o        (s_err),
        .first_fail_o     (s_ff),
        .first_fail_vld_o (s_ffv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Pulses start, follows the 16-cycle run vector by vector, then checks the results.
    task automatic run_check(input logic [1:0] m, input bit poke_busy,
                             input int exp_err, input int exp_ff, input bit exp_ffv,
                             input bit exp_pass);
        mode = m;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("done_cleared", {31'd0, done}, 0);
        check("err_cleared", {28'd0, err}, 0);
        check("ffv_cleared", {31'd0, ffv}, 0);
        for (int c = 0; c < 16; c++) begin
            check("busy_run", {31'd0, busy}, 1);
            check("vector", {29'd0, in1, in2, in3}, c / 2);
            start_i = (poke_busy && c == 5);
            @(negedge clk);
        end
        start_i = 1'b0;
        check("busy_end", {31'd0, busy}, 0);
        check("done", {31'd0, done}, 1);
        check("vector_idle", {29'd0, in1, in2, in3}, 0);
        check("pass", {31'd0, pass}, {31'd0, exp_pass});
        check("err_cnt", {28'd0, err}, exp_err);
        check("first_fail_vld", {31'd0, ffv}, {31'd0, exp_ffv});
        if (exp_ffv) check("first_fail", {29'd0, ff}, exp_ff);
        check("sat_done", {31'd0, s_done}, 1);
        check("sat_err", {30'd0, s_err}, 3);
        check("sat_pass", {31'd0, s_pass}, 0);
        check("sat_first_fail", {29'd0, s_ff}, 1);
        repeat (2) @(negedge clk);
        check("done_held", {31'd0, done}, 1);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        mode    = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {28'd0, err}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);

        run_check(2'd0, 1'b0, 0, 0, 1'b0, 1'b1);
        run_check(2'd1, 1'b0, 7, 1, 1'b1, 1'b0);
        run_check(2'd2, 1'b0, 1, 0, 1'b1, 1'b0);
        run_check(2'd0, 1'b1, 0, 0, 1'b0, 1'b1);

        // Reset while vector 100 is on the outputs, with errors already counted.
        mode = 2'd1;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_vector", {29'd0, in1, in2, in3}, 4);
        check("pre_rst_err", {28'd0, err}, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_vector", {29'd0, in1, in2, in3}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        check("mid_rst_pass", {31'd0, pass}, 0);
        check("mid_rst_err", {28'd0, err}, 0);
        check("mid_rst_ff", {29'd0, ff}, 0);
        check("mid_rst_ffv", {31'd0, ffv}, 0);
        check("mid_rst_sat_err", {30'd0, s_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 0);

        run_check(2'd0, 1'b0, 0, 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
